// File: rtl/rtp_result_collector.sv
// rtp_result_collector
// Receive-side sink for the ray-tracing core's per-ray hit results. Results are
// captured into an on-chip buffer indexed by ray id while collecting; once the
// frame is complete (every ray reported or the core signals finish) the buffer
// is replayed in ray-id order through a one-cycle-latency read port.
//
// Ports:
//   clock, reset         - clock and synchronous active-high reset
//   in_valid/in_ready    - result handshake from the core (ready only while collecting)
//   in_ray_id, in_hitT   - ray id and IEEE-754 single hit distance of a result
//   in_rtp_finish        - core reports the frame finished
//   rd_req               - request the next buffered entry (draining only)
//   rd_valid, rd_ray_id,
//   rd_hitT              - read data, valid one cycle after an accepted rd_req
//   done                 - frame fully drained; held until reset
//   recv_count           - unique results accepted (saturating)
//   miss_count           - accepted results whose hitT equals MISS_VALUE (saturating)
//   dup_err, range_err   - sticky error flags for repeated ids / out-of-range ids
//   collect_cycles       - cycles spent collecting (wraps modulo 2^64)
module rtp_result_collector #(
    parameter int          NUM_RAYS   = 1024,
    parameter int          ID_W       = 10,
    parameter logic [31:0] MISS_VALUE = 32'h7F800000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ray_id,
    input  logic [31:0]     in_hitT,
    input  logic            in_rtp_finish,
    input  logic            rd_req,
    output logic            rd_valid,
    output logic [ID_W-1:0] rd_ray_id,
    output logic [31:0]     rd_hitT,
    output logic            done,
    output logic [31:0]     recv_count,
    output logic [31:0]     miss_count,
    output logic            dup_err,
    output logic            range_err,
    output logic [63:0]     collect_cycles
);

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [31:0]     NUM_RAYS_W = 32'(NUM_RAYS);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_RAYS - 1);

    state_t            state;
    logic [31:0]       buffer_mem [NUM_RAYS];
    logic [NUM_RAYS-1:0] seen;
    logic [ID_W-1:0]   rd_ptr;

    logic [ID_W-1:0]   wr_idx;
    logic              in_xfer;
    logic              id_in_range;
    logic              id_seen;
    logic              new_write;
    logic              is_miss;
    logic [31:0]       recv_next;
    logic              go_drain;

    assign wr_idx   = in_ray_id[ID_W-1:0];
    assign in_ready = (state == COLLECT);

    // Classify the incoming result and decide whether this cycle ends collection.
    // recv_next is the post-update count so the final unique write itself can
    // trigger the move to DRAIN on the same edge it is stored.
    always_comb begin
        in_xfer     = in_valid && (state == COLLECT);
        id_in_range = (in_ray_id < NUM_RAYS_W);
        id_seen     = seen[wr_idx];
        new_write   = in_xfer && id_in_range && !id_seen;
        is_miss     = (in_hitT == MISS_VALUE);
        recv_next   = recv_count;
        if (new_write && (recv_count != 32'hFFFF_FFFF)) begin
            recv_next = recv_count + 32'd1;
        end
        go_drain = (state == COLLECT) && (in_rtp_finish || (recv_next >= NUM_RAYS_W));
    end

    // Result storage. Not reset: the seen bits decide whether an entry is
    // meaningful, so stale contents after reset are never observed.
    always_ff @(posedge clock) begin
        if (new_write) begin
            buffer_mem[wr_idx] <= in_hitT;
        end
    end

    // Control FSM, counters, error flags and the registered read port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= COLLECT;
            seen           <= '0;
            rd_ptr         <= '0;
            rd_valid       <= 1'b0;
            rd_ray_id      <= '0;
            rd_hitT        <= '0;
            done           <= 1'b0;
            recv_count     <= '0;
            miss_count     <= '0;
            dup_err        <= 1'b0;
            range_err      <= 1'b0;
            collect_cycles <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (new_write) begin
                        seen[wr_idx] <= 1'b1;
                        recv_count   <= recv_next;
                        if (is_miss && (miss_count != 32'hFFFF_FFFF)) begin
                            miss_count <= miss_count + 32'd1;
                        end
                    end
                    if (in_xfer && id_in_range && id_seen) begin
                        dup_err <= 1'b1;
                    end
                    if (in_xfer && !id_in_range) begin
                        range_err <= 1'b1;
                    end
                    // The leaving cycle is not counted, so the counter freezes
                    // at the number of cycles spent before the trigger.
                    if (go_drain) begin
                        state <= DRAIN;
                    end else begin
                        collect_cycles <= collect_cycles + 64'd1;
                    end
                end
                DRAIN: begin
                    if (rd_req) begin
                        rd_valid  <= 1'b1;
                        rd_ray_id <= rd_ptr;
                        rd_hitT   <= seen[rd_ptr] ? buffer_mem[rd_ptr] : MISS_VALUE;
                        rd_ptr    <= rd_ptr + ID_W'(1);
                        if (rd_ptr == LAST_ID) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtp_result_collector.sv
// tb_rtp_result_collector
// Directed bench for rtp_result_collector with a 4-ray frame. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_rtp_result_collector;

    localparam logic [31:0] MISS = 32'h7F800000;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ray_id;
    logic [31:0] in_hitT;
    logic        in_rtp_finish;
    logic        rd_req;
    logic        rd_valid;
    logic [1:0]  rd_ray_id;
    logic [31:0] rd_hitT;
    logic        done;
    logic [31:0] recv_count;
    logic [31:0] miss_count;
    logic        dup_err;
    logic        range_err;
    logic [63:0] collect_cycles;

    int checks;
    int errors;

    rtp_result_collector #(
        .NUM_RAYS  (4),
        .ID_W      (2),
        .MISS_VALUE(MISS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ray_id     (in_ray_id),
        .in_hitT       (in_hitT),
        .in_rtp_finish (in_rtp_finish),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_ray_id     (rd_ray_id),
        .rd_hitT       (rd_hitT),
        .done          (done),
        .recv_count    (recv_count),
        .miss_count    (miss_count),
        .dup_err       (dup_err),
        .range_err     (range_err),
        .collect_cycles(collect_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] id, input logic [31:0] hit,
                                 input logic finish);
        in_valid      = valid;
        in_ray_id     = id;
        in_hitT       = hit;
        in_rtp_finish = finish;
        step();
        in_valid      = 1'b0;
        in_rtp_finish = 1'b0;
    endtask

    task automatic doReset();
        reset    = 1'b1;
        in_valid = 1'b0;
        rd_req   = 1'b0;
        in_rtp_finish = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drainAndCheck(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_hit [4];
        exp_hit = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            step();
            checkOutput({tag, "_rd_valid"}, 64'(rd_valid), 64'd1);
            checkOutput({tag, "_rd_ray_id"}, 64'(rd_ray_id), 64'(i));
            checkOutput({tag, "_rd_hitT"}, 64'(rd_hitT), 64'(exp_hit[i]));
            checkOutput({tag, "_done"}, 64'(done), (i == 3) ? 64'd1 : 64'd0);
        end
        rd_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        in_ray_id = '0;
        in_hitT   = '0;

        // Reset state
        doReset();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_rd_ray_id", 64'(rd_ray_id), 64'd0);
        checkOutput("rst_rd_hitT", 64'(rd_hitT), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_recv", 64'(recv_count), 64'd0);
        checkOutput("rst_miss", 64'(miss_count), 64'd0);
        checkOutput("rst_errs", {62'd0, dup_err, range_err}, 64'd0);
        checkOutput("rst_cycles", collect_cycles, 64'd0);

        // Full frame, out-of-order ids, back-to-back
        in_valid = 1'b1;
        in_ray_id = 2; in_hitT = 32'h3F800000; step();
        checkOutput("t1_ready_mid", 64'(in_ready), 64'd1);
        in_ray_id = 0; in_hitT = 32'h40000000; step();
        in_ray_id = 3; in_hitT = 32'h7F800000; step();
        in_ray_id = 1; in_hitT = 32'h40400000; step();
        in_valid = 1'b0;
        checkOutput("t1_in_ready_drain", 64'(in_ready), 64'd0);
        checkOutput("t1_recv", 64'(recv_count), 64'd4);
        checkOutput("t1_miss", 64'(miss_count), 64'd1);
        checkOutput("t1_rd_valid_idle", 64'(rd_valid), 64'd0);
        drainAndCheck("t1", 32'h40000000, 32'h40400000, 32'h3F800000, 32'h7F800000);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        checkOutput("t1_done_hold_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("t1_done_hold", 64'(done), 64'd1);

        // Sparse frame ended by finish
        doReset();
        applyStimulus(1'b1, 32'd1, 32'h41200000, 1'b0);
        checkOutput("t2_ready_before_finish", 64'(in_ready), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        checkOutput("t2_in_ready", 64'(in_ready), 64'd0);
        checkOutput("t2_recv", 64'(recv_count), 64'd1);
        drainAndCheck("t2", MISS, 32'h41200000, MISS, MISS);

        // Duplicate id keeps the first value
        doReset();
        applyStimulus(1'b1, 32'd2, 32'h3F800000, 1'b0);
        applyStimulus(1'b1, 32'd2, 32'h40000000, 1'b0);
        checkOutput("t3_dup_err", 64'(dup_err), 64'd1);
        checkOutput("t3_range_err", 64'(range_err), 64'd0);
        checkOutput("t3_recv", 64'(recv_count), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        drainAndCheck("t3", MISS, MISS, 32'h3F800000, MISS);

        // Out-of-range id is dropped (its low bits alias entry 3)
        doReset();
        applyStimulus(1'b1, 32'd0, 32'h12345678, 1'b0);
        applyStimulus(1'b1, 32'd7, 32'h3F800000, 1'b0);
        checkOutput("t4_range_err", 64'(range_err), 64'd1);
        checkOutput("t4_dup_err", 64'(dup_err), 64'd0);
        checkOutput("t4_recv", 64'(recv_count), 64'd1);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        drainAndCheck("t4", 32'h12345678, MISS, MISS, MISS);

        // Reset in the middle of a drain
        doReset();
        applyStimulus(1'b1, 32'd1, 32'h40800000, 1'b1);
        rd_req = 1'b1;
        step();
        checkOutput("t5_rd0_hitT", 64'(rd_hitT), 64'(MISS));
        step();
        checkOutput("t5_rd1_hitT", 64'(rd_hitT), 64'h40800000);
        rd_req = 1'b0;
        reset  = 1'b1;
        step();
        reset  = 1'b0;
        checkOutput("t5_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t5_rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("t5_recv", 64'(recv_count), 64'd0);
        checkOutput("t5_cycles", collect_cycles, 64'd0);
        checkOutput("t5_done", 64'(done), 64'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
        drainAndCheck("t5", MISS, MISS, MISS, MISS);

        // Last result coincides with finish after 10 idle collect cycles
        doReset();
        for (int i = 0; i < 10; i++) begin
            step();
        end
        checkOutput("t6_cycles_pre", collect_cycles, 64'd10);
        applyStimulus(1'b1, 32'd0, 32'h40A00000, 1'b1);
        checkOutput("t6_cycles", collect_cycles, 64'd10);
        checkOutput("t6_recv", 64'(recv_count), 64'd1);
        checkOutput("t6_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_ray_id = 1; in_hitT = 32'h41000000;
        step(); step(); step();
        in_valid = 1'b0;
        checkOutput("t6_cycles_frozen", collect_cycles, 64'd10);
        checkOutput("t6_recv_ignored", 64'(recv_count), 64'd1);
        drainAndCheck("t6", 32'h40A00000, MISS, MISS, MISS);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rtp_result_collector.md
# rtp_result_collector

Receive-side sink for the ray-tracing core's per-ray hit results (`ray_id`, `hitT`, `rtp_finish`). It is the counterpart of the ray/BVH/triangle RAM preload path: it captures every result into an on-chip buffer indexed by ray id and tracks completion. Once collection ends it replays the buffer in ray-id order through a read port, so benches and host logic can drain the output image deterministically.

## Interface
Parameters:
- `NUM_RAYS`, default 1024: number of rays in a frame; buffer depth.
- `ID_W`, default 10: index width, equal to clog2(NUM_RAYS).
- `MISS_VALUE`, default 32'h7F800000: hitT value meaning "no hit" (+inf); also returned for ids never reported.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: result from core valid.
- `in_ready` out 1: collector accepts a result.
- `in_ray_id` in 32: ray id of the result.
- `in_hitT` in 32: IEEE-754 single hit distance.
- `in_rtp_finish` in 1: core reports the frame finished.
- `rd_req` in 1: request the next buffered result (DRAIN only).
- `rd_valid` out 1: read data valid.
- `rd_ray_id` out ID_W: id of the read entry.
- `rd_hitT` out 32: hitT of the read entry.
- `done` out 1: frame drained.
- `recv_count` out 32: unique results accepted.
- `miss_count` out 32: accepted results with hitT == MISS_VALUE.
- `dup_err` out 1: sticky; an already-seen id was received again.
- `range_err` out 1: sticky; an id >= NUM_RAYS was received.
- `collect_cycles` out 64: cycles spent in COLLECT.

## Operation
- States: COLLECT (reset state), DRAIN, DONE.
- COLLECT:
  - `in_ready`=1; a result transfers when in_valid && in_ready.
  - In-range, unseen id: write the buffer at `in_ray_id[ID_W-1:0]`, set its seen bit, increment recv_count. Increment miss_count if hitT == MISS_VALUE (bitwise compare).
  - Seen id: the buffer keeps the first value, dup_err is set, and no counter changes.
  - id >= NUM_RAYS: dropped and range_err is set.
  - collect_cycles increments every COLLECT cycle.
- COLLECT -> DRAIN when recv_count reaches NUM_RAYS (including on the cycle of the final accepted write) or when in_rtp_finish=1.
  - A transfer in the same cycle as in_rtp_finish is accepted first, then the state transitions.
- DRAIN:
  - `in_ready`=0 and in_valid is ignored.
  - Read pointer starts at 0. Each rd_req reads entry `ptr`, then ptr increments.
  - Unseen entries read as MISS_VALUE.
  - rd_req when ptr == NUM_RAYS-1 reads the last entry; the state moves to DONE.
- DONE:
  - done=1 and everything holds. rd_req and in_valid are ignored.
  - Only reset leaves DONE.
- Counter widths: recv_count and miss_count saturate at 2^32-1. collect_cycles wraps modulo 2^64.

## Timing
- Reset values: in_ready=1 (the state is COLLECT), rd_valid=0, rd_ray_id=0, rd_hitT=0, done=0. All counters are 0, both error flags are 0, all seen bits are cleared, and the read pointer is 0.
- Reset asserted mid-frame or mid-DRAIN discards all data on the next edge.
- in_ready is combinational from state; there is no skid buffer, so throughput is 1 result/cycle.
- Write is visible to a subsequent read with no hazard, since reads occur only in DRAIN.
- Read latency is 1 cycle: rd_req at edge N gives rd_valid=1 with rd_ray_id/rd_hitT during cycle N+1. rd_valid=0 in any cycle with no preceding accepted rd_req. Back-to-back rd_req streams 1 entry/cycle.
- DRAIN entry: DRAIN is entered on the edge after the triggering transfer/finish. An rd_req in the first DRAIN cycle is accepted.
- DONE/done: state=DONE and done=1 in the same cycle as the final rd_valid.
- collect_cycles freezes on the edge COLLECT is left.

## Test plan
- NUM_RAYS=4: send ids 2,0,3,1 with hitT 3F800000, 40000000, 7F800000, 40400000 back-to-back.
  - DRAIN is entered after the 4th result; recv_count=4, miss_count=1.
  - Four rd_req cycles yield (0,40000000), (1,40400000), (2,3F800000), (3,7F800000).
  - done=1 with the last rd_valid.
- Send only id 1 (41200000), then pulse in_rtp_finish.
  - Drain yields MISS_VALUE for ids 0,2,3 and 41200000 for id 1; recv_count=1.
- Send id 2 twice (3F800000, then 40000000).
  - dup_err=1, recv_count=1, and the drained entry 2 equals 3F800000.
- Send id 7 with NUM_RAYS=4.
  - range_err=1, recv_count unchanged, and no buffer entry altered.
- In DRAIN, issue rd_req for 2 cycles, then assert reset.
  - Next cycle: state COLLECT, in_ready=1, counters 0, rd_valid=0.
  - A fresh drain after finish returns MISS_VALUE everywhere.
- The last result coincides with in_rtp_finish, and 10 COLLECT cycles precede it.
  - The result is stored, collect_cycles=10 and frozen, and in_valid in DRAIN is ignored (in_ready=0).
